accum_engine: RTL

ACCUM_ENGINE -- requirements
Module: accum_engine

---
 rtl/accum_pkg.sv | 21 ++
 rtl/accum_add.sv | 39 +++
 rtl/accum_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// ----------------------------------------------------------------------------
// accum_pkg
// Shared types and default widths for the accumulate engine.
//   state_e    : control FSM states (IDLE, RUN, DONE)
//   DATA_W_DEF : default operand width
//   ACC_W_DEF  : default accumulator / result width
//   ADDR_W_DEF : default operand memory address width
// ----------------------------------------------------------------------------
package accum_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/accum_add.sv
// ----------------------------------------------------------------------------
// accum_add
// Combinational accumulator adder: sum = acc + zero-extended operand.
// Build option ACCUM_SAT_EN:
//   defined   -> the sum clamps at 2^ACC_W-1 and ovf flags the clamp
//   undefined -> the sum wraps modulo 2^ACC_W (no ovf port)
// Ports:
//   acc     in  ACC_W   current accumulator value
//   operand in  DATA_W  operand to add
//   sum     out ACC_W   new accumulator value
//   ovf     out 1       carry out of the accumulator (ACCUM_SAT_EN only)
// ----------------------------------------------------------------------------
module accum_add
  import accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  output logic [ACC_W-1:0]  sum
`ifdef ACCUM_SAT_EN
  ,
  output logic              ovf
`endif
);

`ifdef ACCUM_SAT_EN
  // One extra bit keeps the carry so the clamp can be detected.
  logic [ACC_W:0] wide_s;

  assign wide_s = {1'b0, acc} + (ACC_W+1)'(operand);
  assign ovf    = wide_s[ACC_W];
  assign sum    = wide_s[ACC_W] ? {ACC_W{1'b1}} : wide_s[ACC_W-1:0];
`else
  assign sum = acc + ACC_W'(operand);
`endif

endmodule

// File: rtl/accum_engine.sv
// ----------------------------------------------------------------------------
// accum_engine
// Reads len operands from an external memory (one-cycle read latency) and
// sums them. rd gates read issue, act gates accumulation; an operand that
// returns while act is low waits in a one-entry hold register.
// Build option ACCUM_SAT_EN: saturating accumulation with a sticky clamp
// flag forcing the result to all ones; default build wraps modulo 2^ACC_W.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   rd          read request; a rising edge in IDLE starts an operation
//   act         accumulate enable
//   len         operand count, sampled at start
//   mem_rd_en   operand memory read strobe
//   mem_addr    operand memory address
//   mem_rdata   operand data, valid one cycle after mem_rd_en
//   done        one-cycle completion pulse
//   result      final sum, held until the next completion
// ----------------------------------------------------------------------------
module accum_engine
  import accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              act,
  input  logic [ADDR_W:0]   len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic [ACC_W-1:0]  result
);

  state_e            state_r, state_nxt_s;
  logic              rd_q_r, start_s, issue_ok_s, fin_s, done_r;
  logic [ADDR_W:0]   len_q_r, issued_r, cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ACC_W-1:0]  acc_r, acc_nxt_s, sum_s, result_r, result_nxt_s;
  logic              rvalid_r, hold_vld_r, hold_vld_nxt_s, add_en_s;
  logic [DATA_W-1:0] hold_data_r, hold_data_nxt_s, operand_s;
`ifdef ACCUM_SAT_EN
  logic              ovf_s, sat_r, sat_hit_s;
`endif

  assign start_s = rd & ~rd_q_r;

  // Issue also stalls while a returning operand is headed for the hold slot,
  // so the slot is always free when the next read data arrives.
  assign issue_ok_s = (state_r == RUN) & rd & (issued_r < len_q_r) &
                      ~hold_vld_r & ~(rvalid_r & ~act);

  assign mem_rd_en = issue_ok_s;
  assign mem_addr  = addr_r;
  assign done      = done_r;
  assign result    = result_r;

  accum_add #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_add (
    .acc     (acc_r),
    .operand (operand_s),
    .sum     (sum_s)
`ifdef ACCUM_SAT_EN
    ,
    .ovf     (ovf_s)
`endif
  );

  // Operand steering: held operand first, then fresh read data, else park it.
  always_comb begin
    add_en_s        = 1'b0;
    operand_s       = mem_rdata;
    hold_vld_nxt_s  = hold_vld_r;
    hold_data_nxt_s = hold_data_r;
    if (state_r == RUN) begin
      if (act & hold_vld_r) begin
        add_en_s  = 1'b1;
        operand_s = hold_data_r;
        if (rvalid_r) begin
          hold_data_nxt_s = mem_rdata;
          hold_vld_nxt_s  = 1'b1;
        end else begin
          hold_vld_nxt_s  = 1'b0;
        end
      end else if (act & rvalid_r) begin
        add_en_s  = 1'b1;
        operand_s = mem_rdata;
      end else if (rvalid_r & ~hold_vld_r) begin
        hold_vld_nxt_s  = 1'b1;
        hold_data_nxt_s = mem_rdata;
      end else begin
        hold_vld_nxt_s  = hold_vld_r;
      end
    end else begin
      add_en_s = 1'b0;
    end
    acc_nxt_s = add_en_s ? sum_s : acc_r;
    cnt_nxt_s = cnt_r + {{ADDR_W{1'b0}}, add_en_s};
    fin_s     = (state_r == RUN) && (cnt_nxt_s == len_q_r);
  end

`ifdef ACCUM_SAT_EN
  assign sat_hit_s    = sat_r | (add_en_s & ovf_s);
  assign result_nxt_s = sat_hit_s ? {ACC_W{1'b1}} : acc_nxt_s;

  // Sticky clamp flag, cleared at each start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r <= 1'b0;
    end else if ((state_r == IDLE) && start_s) begin
      sat_r <= 1'b0;
    end else begin
      sat_r <= sat_hit_s;
    end
  end
`else
  assign result_nxt_s = acc_nxt_s;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start_s ? RUN : IDLE;
      RUN:     state_nxt_s = fin_s ? DONE : RUN;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath registers: issue pointer, accumulator, hold slot, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q_r      <= 1'b0;
      done_r      <= 1'b0;
      len_q_r     <= {(ADDR_W+1){1'b0}};
      issued_r    <= {(ADDR_W+1){1'b0}};
      cnt_r       <= {(ADDR_W+1){1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      result_r    <= {ACC_W{1'b0}};
      rvalid_r    <= 1'b0;
      hold_vld_r  <= 1'b0;
      hold_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_q_r <= rd;
      done_r <= (state_nxt_s == DONE);
      if ((state_r == IDLE) && start_s) begin
        len_q_r    <= len;
        issued_r   <= {(ADDR_W+1){1'b0}};
        cnt_r      <= {(ADDR_W+1){1'b0}};
        addr_r     <= {ADDR_W{1'b0}};
        acc_r      <= {ACC_W{1'b0}};
        rvalid_r   <= 1'b0;
        hold_vld_r <= 1'b0;
      end else begin
        rvalid_r    <= issue_ok_s;
        acc_r       <= acc_nxt_s;
        cnt_r       <= cnt_nxt_s;
        hold_vld_r  <= hold_vld_nxt_s;
        hold_data_r <= hold_data_nxt_s;
        if (issue_ok_s) begin
          addr_r   <= addr_r + ADDR_W'(1'b1);
          issued_r <= issued_r + (ADDR_W+1)'(1'b1);
        end
        if (fin_s) begin
          result_r <= result_nxt_s;
        end
      end
    end
  end

endmodule
